// File: rtl/alu_mem_pkg.sv
// Shared definitions for the ALU command sequencer.
//   - Register map of the memory-mapped ALU (operand A, operand B, opcode,
//     execute strobe register).
//   - Sequencer state type.
//   - Opcode width.
package alu_mem_pkg;

    localparam int OP_WIDTH = 3;

    localparam int A_REG    = 0;
    localparam int B_REG    = 1;
    localparam int OP_REG   = 2;
    localparam int EXEC_REG = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_A     = 3'd1,
        WR_B     = 3'd2,
        WR_OP    = 3'd3,
        WR_EXEC  = 3'd4,
        WAIT     = 3'd5,
        CLR_EXEC = 3'd6,
        RESP     = 3'd7
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer.
// Accepts one command (A, B, opcode), programs a memory-mapped ALU with
// four single-cycle writes, waits ALU_LATENCY cycles, captures the result,
// clears the execute register and presents the result until it is consumed.
// Only one command is in flight at a time.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | ready for a command (cmd_ready=1)
// WR_A     | write operand A to A_REG
// WR_B     | write operand B to B_REG
// WR_OP    | write zero-extended opcode to OP_REG
// WR_EXEC  | write 1 to EXEC_REG, load wait counter
// WAIT     | ALU_LATENCY cycles; result captured on the leaving edge
// CLR_EXEC | write 0 to EXEC_REG
// RESP     | rsp_valid=1, held until rsp_ready is sampled high
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_a, cmd_b, cmd_op            command operands and opcode
//   mem_wr, mem_addr, mem_wdata     memory write port toward the ALU
//   alu_res                         ALU result input
//   rsp_valid/rsp_ready, rsp_data   response handshake and captured result
//   busy                            high in every state except IDLE
module alu_cmd_seq
    import alu_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int ALU_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,
    input  logic [OP_WIDTH-1:0]     cmd_op,
    output logic                    mem_wr,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [2*DATA_WIDTH-1:0] alu_res,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
    output logic                    busy
);

    // Counter is loaded with LATENCY-1 so WAIT spans exactly ALU_LATENCY cycles.
    localparam logic [3:0] WAIT_LOAD = 4'(ALU_LATENCY - 1);

    seq_state_e              state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0]   a_q, b_q;
    logic [OP_WIDTH-1:0]     op_q;
    logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                    accept;

    assign accept = cmd_valid && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            rsp_data_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rsp_data_q <= rsp_data_d;
            if (accept) begin
                a_q  <= cmd_a;
                b_q  <= cmd_b;
                op_q <= cmd_op;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rsp_data_d = rsp_data_q;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rsp_valid  = 1'b0;
        cmd_ready  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = WR_A;
            end
            WR_A: begin
                mem_wr    = 1'b1;
                mem_addr  = ADDR_WIDTH'(A_REG);
                mem_wdata = a_q;
                state_d   = WR_B;
            end
            WR_B: begin
                mem_wr    = 1'b1;
                mem_addr  = ADDR_WIDTH'(B_REG);
                mem_wdata = b_q;
                state_d   = WR_OP;
            end
            WR_OP: begin
                mem_wr    = 1'b1;
                mem_addr  = ADDR_WIDTH'(OP_REG);
                mem_wdata = DATA_WIDTH'(op_q);
                state_d   = WR_EXEC;
            end
            WR_EXEC: begin
                mem_wr     = 1'b1;
                mem_addr   = ADDR_WIDTH'(EXEC_REG);
                mem_wdata  = DATA_WIDTH'(1);
                wait_cnt_d = WAIT_LOAD;
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    rsp_data_d = alu_res;
                    state_d    = CLR_EXEC;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            CLR_EXEC: begin
                mem_wr    = 1'b1;
                mem_addr  = ADDR_WIDTH'(EXEC_REG);
                mem_wdata = '0;
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_data = rsp_data_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001: Parameter DATA_WIDTH, default 8: width of operands and memory write data.
REQ-002: Parameter ADDR_WIDTH, default 8: width of memory address.
REQ-003: Parameter ALU_LATENCY, default 2, legal range 1..15: cycles from EXEC write to a valid ALU result.
REQ-004: clk  in  1  single clock; all logic is on its rising edge.
REQ-005: reset  in  1  synchronous, active-high reset.
REQ-006: cmd_valid  in  1  command offered.
REQ-007: cmd_ready  out  1  sequencer can accept a command.
REQ-008: cmd_a  in  DATA_WIDTH  operand A.
REQ-009: cmd_b  in  DATA_WIDTH  operand B.
REQ-010: cmd_op  in  3  ALU opcode.
REQ-011: mem_wr  out  1  memory write strobe.
REQ-012: mem_addr  out  ADDR_WIDTH  memory write address.
REQ-013: mem_wdata  out  DATA_WIDTH  memory write data.
REQ-014: alu_res  in  2*DATA_WIDTH  ALU result.
REQ-015: rsp_valid  out  1  result available.
REQ-016: rsp_ready  in  1  consumer accepts result.
REQ-017: rsp_data  out  2*DATA_WIDTH  captured result.
REQ-018: busy  out  1  high in every state except IDLE.

Function
REQ-019: States SHALL be IDLE, WR_A, WR_B, WR_OP, WR_EXEC, WAIT, CLR_EXEC, RESP.
REQ-020: cmd_ready SHALL be high only in IDLE; a command is accepted on the edge where cmd_valid and cmd_ready are both high, and cmd_a, cmd_b, cmd_op are latched on that edge.
REQ-021: IDLE -> WR_A on acceptance; WR_A -> WR_B -> WR_OP -> WR_EXEC -> WAIT, each transition unconditional after one cycle.
REQ-022: Writes SHALL be one per cycle with mem_wr=1: WR_A addr 0 data A; WR_B addr 1 data B; WR_OP addr 2 data op zero-extended; WR_EXEC addr 3 data 1.
REQ-023: WAIT SHALL last exactly ALU_LATENCY cycles, counted by an internal down-counter loaded on entry.
REQ-024: On the edge leaving WAIT, alu_res SHALL be captured into rsp_data; the next state is CLR_EXEC.
REQ-025: CLR_EXEC SHALL write data 0 to addr 3 for one cycle and then go to RESP.
REQ-026: In RESP, rsp_valid SHALL be 1; rsp_data SHALL stay stable until rsp_ready is sampled high; the FSM then returns to IDLE.
REQ-027: Outside the write states, mem_wr, mem_addr and mem_wdata SHALL be 0.
REQ-028: Latency: for a command accepted at edge 0, rsp_valid SHALL first be high in cycle ALU_LATENCY+6 (cycle 8 at the default).
REQ-029: cmd_valid while busy SHALL be ignored, with no latching and no side effect.
REQ-030: With rsp_ready held high, rsp_valid SHALL be high for exactly one cycle; a new command may be accepted the cycle after.
REQ-031: The sequencer SHALL NOT pipeline: at most one command is in flight.

Reset
REQ-032: Reset SHALL force IDLE in any state, including mid-sequence, and SHALL NOT issue a CLR_EXEC write.
REQ-033: Reset values: cmd_ready=1 after release, mem_wr=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, busy=0, wait counter=0.

Structure
REQ-034: A shared package alu_mem_pkg SHALL hold the register addresses A_REG=0, B_REG=1, OP_REG=2, EXEC_REG=3, the state enum, and the opcode width (3).
REQ-035: No sub-module is required; the FSM and the wait counter SHALL live in alu_cmd_seq.

Verification
REQ-036: Defaults; command a=8'h12, b=8'h34, op=3'd0 -> writes (0,12),(1,34),(2,00),(3,01) on consecutive cycles, then (3,00); rsp_data equals the alu_res model value at cycle 8.
REQ-037: rsp_ready held low for 5 cycles in RESP -> rsp_valid high for 5+ cycles, rsp_data constant, cmd_ready low throughout.
REQ-038: cmd_valid pulsed during WAIT with a=8'hFF -> ignored; the next write sequence still uses the original operands.
REQ-039: reset asserted in WR_OP -> next cycle IDLE, mem_wr=0, no write to addr 3; a subsequent command completes normally.
REQ-040: ALU_LATENCY=1 and ALU_LATENCY=15 -> rsp_valid first high at cycle 7 and cycle 21 respectively.
REQ-041: Back-to-back commands with rsp_ready tied high -> second command accepted one cycle after the first response, with no lost or duplicated writes.
